lc3_fetch: RTL and testbench

//  Instruction-fetch sequencer for the LC-3 datapath; sits between the PC register and the memory port.
//  On start it captures the current pc and issues one memory read with a ready handshake.
//  It latches the returned word into the IR and then pulses ld_pc with pcmux=2'b00 so the PC increments.
//  The control FSM consumes done/ir/ir_valid to begin decode.

---
 rtl/lc3_fetch.sv | 171 +++++++++++++++++
 tb/tb_lc3_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_fetch.sv
// -----------------------------------------------------------------------------
// lc3_fetch
//
// Instruction-fetch sequencer for the LC-3 datapath. It sits between the PC
// register and the memory read port. A start request from the control FSM
// captures the current PC and issues one memory read, with mem_en held until
// mem_ready is sampled high. The returned word is latched into the IR, and a
// one-cycle ld_pc/done pulse follows. During that pulse pcmux selects pc+1, so
// the PC register increments at the next edge.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   When defined, a fetch that sees no mem_ready for TIMEOUT_CYCLES REQ cycles
//   is abandoned. This raises a one-cycle fetch_err pulse.
//   When undefined, REQ waits indefinitely and fetch_err is tied to 0.
//
// Parameters
//   IR_RESET_VAL    value loaded into ir on reset
//   TIMEOUT_CYCLES  REQ cycles without mem_ready before abort (2..255);
//                   only meaningful with FETCH_TIMEOUT_EN
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active-low (0 = reset)
//   start      in   1   fetch request; honoured only in IDLE
//   flush      in   1   abort an outstanding fetch / invalidate ir
//   pc         in   16  current PC from the PC register
//   mem_addr   out  16  registered read address
//   mem_en     out  1   read request, held until mem_ready sampled high
//   mem_ready  in   1   mem_rdata valid this cycle
//   mem_rdata  in   16  read data from memory
//   ir         out  16  instruction register
//   ir_valid   out  1   ir holds a completed, unflushed fetch
//   ld_pc      out  1   PC load strobe, one-cycle pulse
//   pcmux      out  2   PC source select, always 2'b00 (pc+1)
//   done       out  1   one-cycle pulse: fetch complete, ir updated
//   busy       out  1   sequencer not in IDLE
//   fetch_err  out  1   one-cycle pulse on fetch timeout
// -----------------------------------------------------------------------------
module lc3_fetch #(
   parameter logic [15:0] IR_RESET_VAL   = 16'h0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [15:0] pc,
   output logic [15:0] mem_addr,
   output logic        mem_en,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic [15:0] ir,
   output logic        ir_valid,
   output logic        ld_pc,
   output logic [1:0]  pcmux,
   output logic        done,
   output logic        busy,
   output logic        fetch_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0] state;

`ifdef FETCH_TIMEOUT_EN
   // Last count value before the abort fires. The counter reaches it on the
   // TIMEOUT_CYCLES-th REQ cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wait_cnt;
   logic       fetch_err_q;

   assign fetch_err = fetch_err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign fetch_err      = 1'b0;
`endif

   // The PC always advances by one after a fetch; no other source is used.
   assign pcmux = 2'b00;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         mem_addr <= 16'h0000;
         mem_en   <= 1'b0;
         ir       <= IR_RESET_VAL;
         ir_valid <= 1'b0;
         ld_pc    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt    <= 8'd0;
         fetch_err_q <= 1'b0;
`endif
      end else begin
         // Strobes default low, so each one lasts only a single cycle.
         ld_pc <= 1'b0;
         done  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         fetch_err_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               // flush beats start: invalidate and stay idle.
               if (flush) begin
                  ir_valid <= 1'b0;
               end else if (start) begin
                  mem_addr <= pc;
                  mem_en   <= 1'b1;
                  ir_valid <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt <= 8'd0;
`endif
               end
            end

            ST_REQ: begin
               // flush wins over a same-cycle mem_ready; ir keeps its old word.
               if (flush) begin
                  mem_en   <= 1'b0;
                  ir_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else if (mem_ready) begin
                  ir       <= mem_rdata;
                  ir_valid <= 1'b1;
                  mem_en   <= 1'b0;
                  ld_pc    <= 1'b1;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (wait_cnt == TIMEOUT_LAST) begin
                  fetch_err_q <= 1'b1;
                  mem_en      <= 1'b0;
                  ir_valid    <= 1'b0;
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end

            ST_DONE: begin
               // The fetch is already committed, so the ld_pc/done pulse
               // finishes regardless of flush. A flush only drops ir_valid.
               if (flush) begin
                  ir_valid <= 1'b0;
               end
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               mem_en <= 1'b0;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_fetch.sv
// -----------------------------------------------------------------------------
// tb_lc3_fetch
//
// Directed bench for lc3_fetch.
//
// A table of single-cycle vectors is applied first. Each vector holds the
// inputs driven before a rising edge and the outputs expected after that edge.
// Hand-written sequences then cover the multi-cycle cases:
//   - delayed mem_ready
//   - no mem_ready at all (timeout, or waiting forever without the macro)
//   - asynchronous reset in the middle of a fetch
//
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_lc3_fetch;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [15:0] pc;
   logic [15:0] mem_addr;
   logic        mem_en;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ld_pc;
   logic [1:0]  pcmux;
   logic        done;
   logic        busy;
   logic        fetch_err;

   int n_cmp;
   int n_err;

   lc3_fetch #(
      .IR_RESET_VAL  (16'h0000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .flush    (flush),
      .pc       (pc),
      .mem_addr (mem_addr),
      .mem_en   (mem_en),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .ir       (ir),
      .ir_valid (ir_valid),
      .ld_pc    (ld_pc),
      .pcmux    (pcmux),
      .done     (done),
      .busy     (busy),
      .fetch_err(fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        start;
      logic        flush;
      logic        rdy;
      logic [15:0] pc;
      logic [15:0] rdata;
      logic        en;
      logic [15:0] addr;
      logic [15:0] ir;
      logic        iv;
      logic        ld;
      logic        dn;
      logic        bsy;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   int en_cnt;
   int done_cnt;
   int ld_cnt;
   int err_cnt;
   int err_at;
   int addr_bad;

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      start     = 1'b0;
      flush     = 1'b0;
      pc        = 16'h0000;
      mem_ready = 1'b0;
      mem_rdata = 16'h0000;

      //                start flush rdy  pc        rdata      en   addr      ir        iv   ld   dn   bsy
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'h3000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h3000, 16'h1261, 1'b0, 16'h3000, 16'h1261, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 1'b0, 16'h3000, 16'h1261, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h3001, 16'h0000, 1'b1, 16'h3001, 16'h1261, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h3001, 16'h2262, 1'b0, 16'h3001, 16'h2262, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h3002, 16'h0000, 1'b0, 16'h3001, 16'h2262, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h3002, 16'h0000, 1'b1, 16'h3002, 16'h2262, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h3002, 16'h3263, 1'b0, 16'h3002, 16'h3263, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h3003, 16'h0000, 1'b0, 16'h3002, 16'h3263, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h3003, 16'h0000, 1'b0, 16'h3002, 16'h3263, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000, 1'b1, 16'h4000, 16'h3263, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h4000, 16'hdead, 1'b0, 16'h4000, 16'h3263, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h4001, 16'h0000, 1'b1, 16'h4001, 16'h3263, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h4001, 16'h5555, 1'b0, 16'h4001, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h4002, 16'h0000, 1'b0, 16'h4001, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h4002, 16'h7777, 1'b0, 16'h4001, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset asserted before any clock edge: outputs must settle immediately.
      #2 rst = 1'b0;
      #1;
      chk("rst_mem_en",    16'(mem_en),    16'h0);
      chk("rst_mem_addr",  mem_addr,       16'h0000);
      chk("rst_ir",        ir,             16'h0000);
      chk("rst_ir_valid",  16'(ir_valid),  16'h0);
      chk("rst_ld_pc",     16'(ld_pc),     16'h0);
      chk("rst_done",      16'(done),      16'h0);
      chk("rst_busy",      16'(busy),      16'h0);
      chk("rst_fetch_err", 16'(fetch_err), 16'h0);
      chk("rst_pcmux",     16'(pcmux),     16'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Single-cycle vector table.
      for (int i = 0; i < NVEC; i++) begin
         start     = vecs[i].start;
         flush     = vecs[i].flush;
         mem_ready = vecs[i].rdy;
         pc        = vecs[i].pc;
         mem_rdata = vecs[i].rdata;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_mem_en", i),   16'(mem_en),    16'(vecs[i].en));
         chk($sformatf("v%0d_mem_addr", i), mem_addr,       vecs[i].addr);
         chk($sformatf("v%0d_ir", i),       ir,             vecs[i].ir);
         chk($sformatf("v%0d_ir_valid", i), 16'(ir_valid),  16'(vecs[i].iv));
         chk($sformatf("v%0d_ld_pc", i),    16'(ld_pc),     16'(vecs[i].ld));
         chk($sformatf("v%0d_done", i),     16'(done),      16'(vecs[i].dn));
         chk($sformatf("v%0d_busy", i),     16'(busy),      16'(vecs[i].bsy));
         chk($sformatf("v%0d_pcmux", i),    16'(pcmux),     16'h0);
         chk($sformatf("v%0d_fetch_err", i),16'(fetch_err), 16'h0);
      end
      start     = 1'b0;
      flush     = 1'b0;
      mem_ready = 1'b0;

      // mem_ready delayed by five cycles; a start arriving mid-wait is dropped.
      pc    = 16'h3001;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      en_cnt   = mem_en ? 1 : 0;
      done_cnt = 0;
      ld_cnt   = 0;
      addr_bad = 0;
      for (int k = 1; k <= 9; k++) begin
         start     = (k == 2);
         pc        = (k == 2) ? 16'h3100 : 16'h3001;
         mem_ready = (k == 6);
         mem_rdata = (k == 6) ? 16'h1234 : 16'hbeef;
         @(posedge clk);
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (done) done_cnt++;
         if (ld_pc) ld_cnt++;
         if (k <= 6 && mem_addr != 16'h3001) addr_bad++;
      end
      start     = 1'b0;
      mem_ready = 1'b0;
      chk("dly_mem_en_cycles", 16'(en_cnt),   16'd6);
      chk("dly_done_pulses",   16'(done_cnt), 16'd1);
      chk("dly_ld_pc_pulses",  16'(ld_cnt),   16'd1);
      chk("dly_addr_unstable", 16'(addr_bad), 16'd0);
      chk("dly_ir",            ir,            16'h1234);
      chk("dly_ir_valid",      16'(ir_valid), 16'h1);
      chk("dly_busy_end",      16'(busy),     16'h0);

      // mem_ready never arrives.
      pc    = 16'h3003;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      en_cnt  = mem_en ? 1 : 0;
      err_cnt = 0;
      err_at  = 0;
      ld_cnt  = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (ld_pc || done) ld_cnt++;
         if (fetch_err) begin
            err_cnt++;
            err_at = k;
         end
      end
`ifdef FETCH_TIMEOUT_EN
      chk("to_mem_en_cycles", 16'(en_cnt),  16'd16);
      chk("to_err_pulses",    16'(err_cnt), 16'd1);
      chk("to_err_cycle",     16'(err_at),  16'd16);
      chk("to_busy",          16'(busy),    16'h0);
`else
      chk("to_mem_en_cycles", 16'(en_cnt),  16'd21);
      chk("to_err_pulses",    16'(err_cnt), 16'd0);
      chk("to_busy",          16'(busy),    16'h1);
`endif
      chk("to_no_ld_pc", 16'(ld_cnt), 16'd0);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      chk("to_flush_mem_en", 16'(mem_en), 16'h0);
      chk("to_flush_busy",   16'(busy),   16'h0);

      // Asynchronous reset in the middle of a REQ.
      pc    = 16'h6000;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("arst_pre_mem_en", 16'(mem_en), 16'h1);
      #2 rst = 1'b0;
      #1;
      chk("arst_mem_en",   16'(mem_en),   16'h0);
      chk("arst_mem_addr", mem_addr,      16'h0000);
      chk("arst_ir",       ir,            16'h0000);
      chk("arst_ir_valid", 16'(ir_valid), 16'h0);
      chk("arst_busy",     16'(busy),     16'h0);
      mem_ready = 1'b1;
      mem_rdata = 16'h9999;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      chk("arst_no_ld_pc", 16'(ld_pc), 16'h0);
      chk("arst_no_done",  16'(done),  16'h0);
      chk("arst_ir_kept",  ir,         16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
